// File: rtl/gpio_period_meter.sv
// rtl/gpio_period_meter.sv - glitch-filtered GPIO square-wave period and high-time meter
`timescale 1ns/1ps
module gpio_period_meter #(
    parameter int CNT_W         = 24,
    parameter int FILTER_CYCLES = 4,
    parameter int TIMEOUT       = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gpio_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    localparam int STAB_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               sync1;
    logic               sync2;
    logic               filt;
    logic               filt_d;
    logic [STAB_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   hi_latch;
    logic               rise;
    logic               fall;
    logic               cnt_at_limit;
    logic [CNT_W-1:0]   period_next;
    logic [CNT_W-1:0]   high_next;
    logic               valid_next;
    logic               timeout_next;

    assign rise         = filt & ~filt_d;
    assign fall         = ~filt & filt_d;
    assign cnt_at_limit = (cnt == TMO);

    // A new level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            stab_cnt <= '0;
            cnt      <= '0;
            hi_latch <= '0;
        end else begin
            sync1  <= gpio_in;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (stab_cnt == STAB_MAX) begin
                    filt     <= sync2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + STAB_W'(1);
                end
            end else begin
                stab_cnt <= '0;
            end

            // Saturating at TIMEOUT keeps a dead line from wrapping into a bogus period.
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt < TMO) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (fall) begin
                hi_latch <= cnt;
            end
        end
    end

    always_comb begin
        state_next   = state;
        period_next  = period;
        high_next    = high_time;
        valid_next   = 1'b0;
        timeout_next = timeout;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_next   = S_MEAS;
                    timeout_next = 1'b0;
                end else if (cnt_at_limit) begin
                    timeout_next = 1'b1;
                end
            end
            S_MEAS: begin
                // A rise landing on the timeout cycle still counts as a measurement.
                if (rise) begin
                    period_next = cnt;
                    high_next   = hi_latch;
                    valid_next  = 1'b1;
                end else if (cnt_at_limit) begin
                    state_next   = S_IDLE;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            period     <= period_next;
            high_time  <= high_next;
            meas_valid <= valid_next;
            timeout    <= timeout_next;
        end
    end

endmodule

// File: tb/tb_gpio_period_meter.sv
// tb/tb_gpio_period_meter.sv - randomized self-checking bench for gpio_period_meter
`timescale 1ns/1ps
module tb_gpio_period_meter;

    localparam int CNT_W = 24;
    localparam int FC    = 4;
    localparam int TMO   = 1000;
    localparam int LAT   = 3 + FC;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic [31:0]      cyc;
    } meas_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        val;
    } tev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             gpio_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;

    meas_t exp_q[$];
    meas_t obs_q[$];
    tev_t  ev_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    prev_rise = 0;
    int    last_fall = 0;
    bit    have_prev = 1'b0;
    logic  to_prev = 1'b0;

    gpio_period_meter #(
        .CNT_W(CNT_W),
        .FILTER_CYCLES(FC),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_in(gpio_in),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) obs_q.push_back(meas_t'{period, high_time, 32'(cyc)});
        if (timeout !== to_prev) ev_q.push_back(tev_t'{32'(cyc), timeout});
        to_prev <= timeout;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a measurement is owed for every rise that follows a rise no more than TMO cycles earlier.
    task automatic model_rise();
        if (have_prev && (cyc - prev_rise) <= TMO)
            exp_q.push_back(meas_t'{CNT_W'(cyc - prev_rise), CNT_W'(last_fall - prev_rise), 32'(cyc + LAT)});
        have_prev = 1'b1;
        prev_rise = cyc;
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            gpio_in = 1'b1;
            model_rise();
            step(hi);
            gpio_in = 1'b0;
            last_fall = cyc;
            step(lo);
        end
    endtask

    task automatic test_reset();
        int c1;
        rst = 1'b1;
        step(3);
        n_cmp++; if (period !== 0)     begin n_fail++; $display("FAIL reset period: got %0d want 0", period); end
        n_cmp++; if (high_time !== 0)  begin n_fail++; $display("FAIL reset high_time: got %0d want 0", high_time); end
        n_cmp++; if (meas_valid !== 0) begin n_fail++; $display("FAIL reset meas_valid: got %0b want 0", meas_valid); end
        n_cmp++; if (timeout !== 0)    begin n_fail++; $display("FAIL reset timeout: got %0b want 0", timeout); end
        rst = 1'b0;
        c1 = cyc;
        exp_q.delete(); obs_q.delete(); ev_q.delete();
        while (cyc < c1 + TMO + 4) step(1);
        n_cmp++;
        if (ev_q.size() != 1 || ev_q[0] !== tev_t'{32'(c1 + TMO + 1), 1'b1}) begin
            n_fail++;
            $display("FAIL idle_timeout: got %0d events first cyc=%0d want 1 event cyc=%0d",
                     ev_q.size(), (ev_q.size() > 0) ? int'(ev_q[0].cyc) : -1, c1 + TMO + 1);
        end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_meas: got %0d want 0", obs_q.size()); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++; if (timeout !== 0) begin n_fail++; $display("FAIL reset_clears_timeout: got %0b want 0", timeout); end
        step(2);
        exp_q.delete(); obs_q.delete(); ev_q.delete();
        have_prev = 1'b0;
    endtask

    task automatic test_square();
        drive_wave(50, 50, 8);
        step(LAT + 4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL square count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].per !== 100 || obs_q[i].hi !== 50) begin
                n_fail++;
                $display("FAIL square meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        n_cmp++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL square timeout_events: got %0d want 0", ev_q.size()); end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    task automatic test_duty_switch();
        drive_wave(30, 70, 4);
        drive_wave(80, 40, 4);
        step(LAT + 4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL duty count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL duty meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        n_cmp++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL duty timeout_events: got %0d want 0", ev_q.size()); end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 12; i++) begin
            gpio_in = 1'b1;
            step((i % 3) + 1);
            gpio_in = 1'b0;
            step($urandom_range(20, 8));
        end
        step(LAT + 4);
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch meas: got %0d want 0", obs_q.size()); end
        n_cmp++; if (ev_q.size() != 0)  begin n_fail++; $display("FAIL glitch timeout_events: got %0d want 0", ev_q.size()); end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    task automatic test_sweep();
        int hi;
        for (int p = 200; p >= 20; p -= 3) begin
            for (int k = 0; k < 2; k++) begin
                hi = int'($urandom_range(p - FC, FC));
                drive_wave(hi, p - hi, 1);
            end
        end
        step(LAT + 4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sweep count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sweep meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        n_cmp++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL sweep timeout_events: got %0d want 0", ev_q.size()); end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    task automatic test_timeout();
        int t_exp;
        int t_first;
        drive_wave(50, 50, 4);
        t_exp = prev_rise + LAT + TMO;
        while (cyc < t_exp + 3) step(1);
        n_cmp++;
        if (ev_q.size() != 1 || ev_q[0] !== tev_t'{32'(t_exp), 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_set: got %0d events first cyc=%0d want 1 event cyc=%0d",
                     ev_q.size(), (ev_q.size() > 0) ? int'(ev_q[0].cyc) : -1, t_exp);
        end
        n_cmp++; if (timeout !== 1 || period !== 100) begin n_fail++; $display("FAIL timeout_hold: got timeout=%0b period=%0d want 1 100", timeout, period); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_run count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL timeout_run meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
        t_first = cyc;
        drive_wave(50, 50, 3);
        step(LAT + 4);
        n_cmp++;
        if (ev_q.size() != 1 || ev_q[0] !== tev_t'{32'(t_first + LAT), 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_clear: got %0d events first cyc=%0d want 1 event cyc=%0d",
                     ev_q.size(), (ev_q.size() > 0) ? int'(ev_q[0].cyc) : -1, t_first + LAT);
        end
        n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin n_fail++; $display("FAIL restart count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    task automatic test_reset_mid();
        drive_wave(40, 60, 3);
        step(5);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL premid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL premid meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        have_prev = 1'b0;
        n_cmp++; if (period !== 0)     begin n_fail++; $display("FAIL midrst period: got %0d want 0", period); end
        n_cmp++; if (high_time !== 0)  begin n_fail++; $display("FAIL midrst high_time: got %0d want 0", high_time); end
        n_cmp++; if (meas_valid !== 0) begin n_fail++; $display("FAIL midrst meas_valid: got %0b want 0", meas_valid); end
        n_cmp++; if (timeout !== 0)    begin n_fail++; $display("FAIL midrst timeout: got %0b want 0", timeout); end
        drive_wave(30, 70, 3);
        step(LAT + 4);
        n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin n_fail++; $display("FAIL postrst count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL postrst meas%0d: got per=%0d hi=%0d cyc=%0d want per=%0d hi=%0d cyc=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].cyc);
            end
        end
        n_cmp++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL postrst timeout_events: got %0d want 0", ev_q.size()); end
        exp_q.delete(); obs_q.delete(); ev_q.delete();
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty_switch();
        test_glitch();
        test_sweep();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
